// File: rtl/adc_sample_writer_pkg.sv
// Shared types and constants for the ADC sample writer.
package adc_sample_writer_pkg;

    // Capture state machine encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_REQ    = 3'd2,
        ST_GAP    = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    // Byte strobes for a full-word write
    localparam logic [3:0] MEM_WSTRB_WORD = 4'hF;

    // Width of a memory word; samples are zero-extended up to this width
    localparam int MEM_DATA_W = 32;

    // Buffer addresses are word aligned; the two low bits are dropped
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/adc_sample_writer_fifo.sv
// Small synchronous FIFO for ADC samples with a flush input.
// Read data is combinational from the head entry; pointers carry an extra
// wrap bit so full and empty can be told apart.
module sample_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic         do_push;
    logic         do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A push into a full FIFO is legal when the head leaves on the same edge
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    assign dout = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; reset and flush both discard all stored entries
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Storage write; contents need no reset because the pointers gate reads
    always_ff @(posedge clk) begin
        if (do_push && !(reset || flush)) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/adc_sample_writer.sv
// ADC sample writer: buffers 12-bit samples and writes each one as a
// zero-extended word into a linear or circular RAM buffer over the native
// memory interface.
//
// Handshakes: the sample stream transfers a beat on a rising edge where
// s_valid && s_ready. The memory write transfers on a rising edge where
// mem_valid && mem_ready; once mem_valid is raised, mem_addr, mem_wdata and
// mem_wstrb stay constant until that edge, and mem_valid then stays low for
// at least one cycle before the next request.
module adc_sample_writer
    import adc_sample_writer_pkg::*;
#(
    parameter int SAMPLE_W   = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic [31:0]         base_addr,
    input  logic [LEN_W-1:0]    num_words,
    input  logic                circular,
    input  logic                s_valid,
    input  logic [SAMPLE_W-1:0] s_data,
    output logic                s_ready,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wdata,
    output logic [3:0]          mem_wstrb,
    output logic                busy,
    output logic                done,
    output logic                overrun,
    output logic [LEN_W-1:0]    wr_count,
    output state_t              dbg_state
);

    localparam int PAD_W = MEM_DATA_W - SAMPLE_W;

    state_t              state_q;
    state_t              state_next;

    logic [31:0]         base_q;
    logic [31:0]         end_q;
    logic [31:0]         ptr_q;
    logic [LEN_W-1:0]    nw_q;
    logic                circ_q;
    logic                stop_pend_q;
    logic                done_q;
    logic                overrun_q;
    logic [LEN_W-1:0]    wr_count_q;
    logic [31:0]         mem_addr_q;
    logic [31:0]         mem_wdata_q;

    logic                start_ok;
    logic                s_ready_c;
    logic                fifo_pop;
    logic                fifo_push;
    logic                fifo_flush;
    logic                fifo_full;
    logic                fifo_empty;
    logic [SAMPLE_W-1:0] fifo_dout;
    logic                launch;
    logic                complete;
    logic                last_linear;
    logic [LEN_W-1:0]    wr_count_inc;
    logic [31:0]         ptr_inc;
    logic [31:0]         base_aligned;

    // The done cycle still counts as busy, so a start there is ignored too
    assign start_ok     = start && (state_q == ST_IDLE) && !done_q;
    assign wr_count_inc = wr_count_q + {{(LEN_W-1){1'b0}}, 1'b1};
    assign last_linear  = !circ_q && (wr_count_inc == nw_q);
    assign ptr_inc      = ptr_q + 32'd4;
    assign base_aligned = word_align(base_addr);

    // Stop discards queued samples; so does the end of any capture
    assign fifo_push  = s_valid && s_ready_c;
    assign fifo_flush = stop || (state_q == ST_FINISH);

    sample_fifo #(
        .W     (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (fifo_flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (s_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Next-state decode plus per-cycle control strobes
    always_comb begin
        state_next = state_q;
        s_ready_c  = 1'b0;
        fifo_pop   = 1'b0;
        launch     = 1'b0;
        complete   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_next = (num_words == '0) ? ST_FINISH : ST_ARMED;
                end
            end
            ST_ARMED: begin
                s_ready_c = !fifo_full;
                if (stop) begin
                    state_next = ST_FINISH;
                end else if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    launch     = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                s_ready_c = !fifo_full;
                if (mem_ready) begin
                    complete = 1'b1;
                    if (stop || stop_pend_q || last_linear) begin
                        state_next = ST_FINISH;
                    end else begin
                        state_next = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                s_ready_c  = !fifo_full;
                state_next = stop ? ST_FINISH : ST_ARMED;
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Configuration, buffer pointer, counters and the request holding registers
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q      <= '0;
            end_q       <= '0;
            ptr_q       <= '0;
            nw_q        <= '0;
            circ_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            wr_count_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            done_q <= (state_q == ST_FINISH);

            if (start_ok) begin
                base_q      <= base_aligned;
                end_q       <= base_aligned + 32'({num_words, 2'b00});
                ptr_q       <= base_aligned;
                nw_q        <= num_words;
                circ_q      <= circular;
                stop_pend_q <= 1'b0;
                overrun_q   <= 1'b0;
                wr_count_q  <= '0;
            end else begin
                // A sample offered while the FIFO cannot take it is lost
                if (busy && s_valid && !s_ready_c) begin
                    overrun_q <= 1'b1;
                end

                // Remember a stop that arrives mid-write until the write ends
                if (state_q == ST_FINISH) begin
                    stop_pend_q <= 1'b0;
                end else if ((state_q == ST_REQ) && stop) begin
                    stop_pend_q <= 1'b1;
                end

                if (launch) begin
                    mem_addr_q  <= ptr_q;
                    mem_wdata_q <= {{PAD_W{1'b0}}, fifo_dout};
                end

                if (complete) begin
                    wr_count_q <= wr_count_inc;
                    ptr_q      <= (circ_q && (ptr_inc == end_q)) ? base_q : ptr_inc;
                end
            end
        end
    end

    assign mem_valid = (state_q == ST_REQ);
    assign mem_wstrb = mem_valid ? MEM_WSTRB_WORD : 4'h0;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign s_ready   = s_ready_c;
    assign busy      = (state_q != ST_IDLE) || done_q;
    assign done      = done_q;
    assign overrun   = overrun_q;
    assign wr_count  = wr_count_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_adc_sample_writer.sv
// Bench for adc_sample_writer: table of capture scenarios plus hand-written
// sequences for backpressure, zero length and reset during a write.
module tb_adc_sample_writer;
    import adc_sample_writer_pkg::*;

    localparam int SW = 12;
    localparam int FD = 4;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [31:0]   base_addr = '0;
    logic [LW-1:0] num_words = '0;
    logic          circular = 1'b0;
    logic          s_valid = 1'b0;
    logic [SW-1:0] s_data = '0;
    logic          s_ready;
    logic          mem_valid;
    logic          mem_ready = 1'b0;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          busy;
    logic          done;
    logic          overrun;
    logic [LW-1:0] wr_count;
    state_t        dbg_state;

    adc_sample_writer #(.SAMPLE_W(SW), .FIFO_DEPTH(FD), .LEN_W(LW)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .base_addr(base_addr), .num_words(num_words), .circular(circular),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .busy(busy),
        .done(done), .overrun(overrun), .wr_count(wr_count),
        .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q[$];
    int          resp_delay = 0;
    int          resp_cnt = 0;
    int          done_cnt = 0;
    bit          prev_complete = 1'b0;
    bit          prev_wait = 1'b0;
    logic [31:0] held_addr;
    logic [31:0] held_data;
    logic [63:0] exp_e;
    logic [31:0] m_base;
    int          m_nw = 1;
    int          m_idx = 0;

    typedef struct {
        logic [31:0] base;
        int          nw;
        bit          circ;
        int          nsamp;
        int          delay;
        int          exp_wr;
    } vec_t;

    vec_t        vecs[5];
    logic [SW-1:0] fixed_data[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Responder, protocol monitor and scoreboard consumer, all on the falling edge
    always @(negedge clk) begin
        if (reset) begin
            mem_ready     = 1'b0;
            resp_cnt      = 0;
            prev_complete = 1'b0;
            prev_wait     = 1'b0;
        end else begin
            if (mem_valid) begin
                mem_ready = (resp_cnt >= resp_delay);
                resp_cnt++;
            end else begin
                mem_ready = 1'b0;
                resp_cnt  = 0;
            end
            check("wstrb", 32'(mem_wstrb), mem_valid ? 32'hF : 32'h0);
            if (prev_complete) check("gap_low", 32'(mem_valid), 32'h0);
            if (prev_wait) begin
                check("hold_valid", 32'(mem_valid), 32'h1);
                check("hold_addr", mem_addr, held_addr);
                check("hold_data", mem_wdata, held_data);
            end
            prev_complete = mem_valid && mem_ready;
            prev_wait     = mem_valid && !mem_ready;
            held_addr     = mem_addr;
            held_data     = mem_wdata;
            if (mem_valid && mem_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected none", mem_addr, mem_wdata);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("wr_addr", mem_addr, exp_e[63:32]);
                    check("wr_data", mem_wdata, exp_e[31:0]);
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 32'h0);
        check({tag, "_mem_valid"}, 32'(mem_valid), 32'h0);
        check({tag, "_mem_addr"}, mem_addr, 32'h0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        check({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_overrun"}, 32'(overrun), 32'h0);
        check({tag, "_wr_count"}, 32'(wr_count), 32'h0);
        check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    task automatic pulse_start(input logic [31:0] b, input int nw, input bit c);
        @(negedge clk);
        base_addr = b;
        num_words = LW'(nw);
        circular  = c;
        start     = 1'b1;
        m_base    = b & 32'hFFFF_FFFC;
        m_nw      = nw;
        m_idx     = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    // Called on a falling edge: offers one sample and queues its expected write if taken
    task automatic offer(input logic [SW-1:0] d, output bit acc);
        s_valid = 1'b1;
        s_data  = d;
        acc     = s_ready;
        if (acc) begin
            exp_q.push_back({m_base + 32'(4 * (m_idx % m_nw)), 32'(d)});
            m_idx++;
        end
    endtask

    task automatic send_one(input logic [SW-1:0] d, input int gap);
        bit acc;
        @(negedge clk);
        offer(d, acc);
        check("accept", 32'(acc), 32'h1);
        @(negedge clk);
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || mem_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("writes_drained", 32'(exp_q.size()), 32'h0);
    endtask

    task automatic wait_done(input int budget, input int d0);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check("done_pulses", 32'(done_cnt - d0), 32'h1);
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          d0;
        bit          acc;
        int          n;
        int          busy_cyc;
        int          done_at;
        logic [SW-1:0] d;

        vecs[0] = '{base: 32'h0000_1000, nw: 3, circ: 1'b0, nsamp: 3, delay: 0, exp_wr: 3};
        vecs[1] = '{base: 32'h0000_2000, nw: 2, circ: 1'b1, nsamp: 5, delay: 0, exp_wr: 5};
        vecs[2] = '{base: 32'hFFFF_FFF8, nw: 4, circ: 1'b1, nsamp: 6, delay: 1, exp_wr: 6};
        vecs[3] = '{base: 32'h0000_1003, nw: 2, circ: 1'b0, nsamp: 2, delay: 2, exp_wr: 2};
        vecs[4] = '{base: $urandom(), nw: 5, circ: 1'b0, nsamp: 5,
                    delay: $urandom_range(0, 3), exp_wr: 5};
        fixed_data[0] = 12'h001;
        fixed_data[1] = 12'h7FF;
        fixed_data[2] = 12'hFFF;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        // Table-driven capture scenarios
        for (int v = 0; v < 5; v++) begin
            resp_delay = vecs[v].delay;
            d0 = done_cnt;
            pulse_start(vecs[v].base, vecs[v].nw, vecs[v].circ);
            for (int k = 0; k < vecs[v].nsamp; k++) begin
                d = (v == 0) ? fixed_data[k] : SW'($urandom_range(0, 4095));
                send_one(d, vecs[v].delay + 4);
            end
            wait_drain(200);
            if (vecs[v].circ) pulse_stop();
            wait_done(50, d0);
            check("vec_wr_count", 32'(wr_count), 32'(vecs[v].exp_wr));
            check("vec_overrun", 32'(overrun), 32'h0);
            check("vec_busy_end", 32'(busy), 32'h0);
        end

        // Backpressure, first-write latency and start while busy
        resp_delay = 10;
        d0 = done_cnt;
        pulse_start(32'h0000_4000, 8, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 1) check("lat_valid_low", 32'(mem_valid), 32'h0);
            if (k == 2) check("lat_valid_high", 32'(mem_valid), 32'h1);
            offer(SW'($urandom_range(0, 4095)), acc);
            check("bp_s_ready", 32'(acc), (k < 5) ? 32'h1 : 32'h0);
        end
        @(negedge clk);
        s_valid = 1'b0;
        check("overrun_set", 32'(overrun), 32'h1);
        base_addr = 32'h0000_9000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_ignored_overrun", 32'(overrun), 32'h1);
        wait_drain(400);
        check("bp_wr_count", 32'(wr_count), 32'h5);
        pulse_stop();
        wait_done(50, d0);
        check("bp_busy_end", 32'(busy), 32'h0);

        // Zero-length capture
        d0 = done_cnt;
        busy_cyc = 0;
        done_at = 0;
        @(negedge clk);
        base_addr = 32'h0000_6000;
        num_words = '0;
        circular = 1'b0;
        start = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            busy_cyc += int'(busy);
            if (done) done_at = i;
        end
        check("zl_busy_cycles", 32'(busy_cyc), 32'h2);
        check("zl_done_cycle", 32'(done_at), 32'h2);
        check("zl_done_pulses", 32'(done_cnt - d0), 32'h1);
        check("zl_overrun_cleared", 32'(overrun), 32'h0);
        check("zl_wr_count", 32'(wr_count), 32'h0);

        // Reset in the middle of a write, then a fresh capture
        resp_delay = 30;
        pulse_start(32'h0000_5000, 4, 1'b0);
        send_one(12'hABC, 0);
        n = 0;
        while (!mem_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("reached_req", 32'(mem_valid), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreq");
        exp_q.delete();
        reset = 1'b0;
        resp_delay = 0;
        d0 = done_cnt;
        pulse_start(32'h0000_3000, 1, 1'b0);
        send_one(12'h123, 4);
        wait_drain(100);
        wait_done(50, d0);
        check("post_reset_wr_count", 32'(wr_count), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
